// File: rtl/struct_field_unpacker.sv
// Accepts one packed {field0, field1} word and replays its fields one beat at a time,
// field0 first, each zero-extended to the wider of the two field widths.
module struct_field_unpacker #(
   parameter int FIELD0_WIDTH = 4,
   parameter int FIELD1_WIDTH = 4,
   localparam int OUT_WIDTH = (FIELD0_WIDTH > FIELD1_WIDTH) ? FIELD0_WIDTH : FIELD1_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [FIELD0_WIDTH+FIELD1_WIDTH-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OUT_WIDTH-1:0]                 out_data,
   output logic                                 out_idx,
   output logic                                 out_last,
   output logic [7:0]                           word_count
);

   localparam int IN_WIDTH = FIELD0_WIDTH + FIELD1_WIDTH;

   // Handshake rule for both ports: a transfer happens on a rising clk edge where
   // valid && ready; valid never waits on ready, and a stalled beat holds its data.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_t;

   state_t                    state;
   logic [IN_WIDTH-1:0]       hold;
   logic [FIELD0_WIDTH-1:0]   field0;
   logic [FIELD1_WIDTH-1:0]   field1;

   assign field0 = hold[IN_WIDTH-1:FIELD1_WIDTH];
   assign field1 = hold[FIELD1_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= '0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  hold  <= in_data;
                  state <= SEND0;
               end
            end
            SEND0: begin
               if (out_ready) state <= SEND1;
            end
            SEND1: begin
               // The next word is taken on the same edge that retires field1, so no bubble.
               if (out_ready) begin
                  word_count <= word_count + 8'd1;
                  if (in_valid) begin
                     hold  <= in_data;
                     state <= SEND0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // out_ready reaches in_ready only; every other output is a decode of registers.
   assign in_ready  = (state == IDLE) || ((state == SEND1) && out_ready);
   assign out_valid = (state == SEND0) || (state == SEND1);
   assign out_idx   = (state == SEND1);
   assign out_last  = (state == SEND1);

   always_comb begin
      out_data = '0;
      case (state)
         SEND0:   out_data = OUT_WIDTH'(field0);
         SEND1:   out_data = OUT_WIDTH'(field1);
         default: out_data = '0;
      endcase
   end

endmodule

// File: tb/tb_struct_field_unpacker.sv
// Bench for struct_field_unpacker: a 6/5 instance checked by a scoreboard plus
// per-scenario inline checks, and a 3/7 instance for the unequal-width split.
module tb_struct_field_unpacker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance a: FIELD0_WIDTH=6, FIELD1_WIDTH=5, OUT_WIDTH=6
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [10:0] a_in_data = '0;
   logic        a_out_valid;
   logic        a_out_ready = 1'b0;
   logic [5:0]  a_out_data;
   logic        a_out_idx;
   logic        a_out_last;
   logic [7:0]  a_word_count;

   // instance b: FIELD0_WIDTH=3, FIELD1_WIDTH=7, OUT_WIDTH=7
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [9:0]  b_in_data = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [6:0]  b_out_data;
   logic        b_out_idx;
   logic        b_out_last;
   logic [7:0]  b_word_count;

   struct_field_unpacker #(.FIELD0_WIDTH(6), .FIELD1_WIDTH(5)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_idx(a_out_idx), .out_last(a_out_last), .word_count(a_word_count)
   );

   struct_field_unpacker #(.FIELD0_WIDTH(3), .FIELD1_WIDTH(7)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_idx(b_out_idx), .out_last(b_out_last), .word_count(b_word_count)
   );

   int tests = 0;
   int fails = 0;
   int exp_wc = 0;
   int acc_cnt = 0;
   logic [6:0] exp_q[$];   // {idx, zero-extended field}

   // Scoreboard for instance a: pushes the model split of every accepted word,
   // pops and compares on every consumed beat. Samples on the falling edge.
   task automatic monitor_a();
      logic [6:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (a_out_valid && a_out_ready) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL sb_beat: unexpected beat idx=%0d data=%h", a_out_idx, a_out_data);
               end else begin
                  exp = exp_q.pop_front();
                  if ({a_out_idx, a_out_data} !== exp || a_out_last !== exp[6]) begin
                     fails++;
                     $display("FAIL sb_beat: got idx=%0d last=%0d data=%h, want idx=%0d last=%0d data=%h",
                              a_out_idx, a_out_last, a_out_data, exp[6], exp[6], exp[5:0]);
                  end
                  if (exp[6]) exp_wc++;
               end
            end
            if (a_in_valid && a_in_ready) begin
               exp_q.push_back({1'b0, a_in_data[10:5]});
               exp_q.push_back({1'b1, 1'b0, a_in_data[4:0]});
               acc_cnt++;
            end
         end
      end
   endtask

   // Leaves the bench at posedge+1 with reset released and all inputs idle.
   task automatic apply_reset();
      rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
      exp_q.delete();
      exp_wc = 0;
      acc_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d beats outstanding, want 0", name, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 6'h00 ||
          a_out_idx !== 1'b0 || a_out_last !== 1'b0 || a_word_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_a: rdy=%b vld=%b data=%h idx=%b last=%b wc=%0d, want 1 0 00 0 0 0",
                  a_in_ready, a_out_valid, a_out_data, a_out_idx, a_out_last, a_word_count);
      end
      tests++;
      if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 7'h00 || b_word_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_b: rdy=%b vld=%b data=%h wc=%0d, want 1 0 00 0",
                  b_in_ready, b_out_valid, b_out_data, b_word_count);
      end
   endtask

   task automatic test_single();
      apply_reset();
      a_in_valid = 1'b1; a_in_data = 11'h553; a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== 6'h2A || a_out_idx !== 1'b0 || a_out_last !== 1'b0) begin
         fails++;
         $display("FAIL single_beat0: vld=%b data=%h idx=%b last=%b, want 1 2a 0 0",
                  a_out_valid, a_out_data, a_out_idx, a_out_last);
      end
      @(posedge clk); #1;
      tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== 6'h13 || a_out_idx !== 1'b1 || a_out_last !== 1'b1) begin
         fails++;
         $display("FAIL single_beat1: vld=%b data=%h idx=%b last=%b, want 1 13 1 1",
                  a_out_valid, a_out_data, a_out_idx, a_out_last);
      end
      @(posedge clk); #1;
      tests++;
      if (a_word_count !== 8'd1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_done: wc=%0d vld=%b rdy=%b, want 1 0 1", a_word_count, a_out_valid, a_in_ready);
      end
      drain("single", 4);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      a_in_valid = 1'b1; a_in_data = 11'h553; a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_in_data = 11'h0AF;
      tests++;
      if (a_in_ready !== 1'b0) begin
         fails++;
         $display("FAIL b2b_send0_rdy: in_ready=%b, want 0", a_in_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (a_in_ready !== 1'b1 || a_out_data !== 6'h13) begin
         fails++;
         $display("FAIL b2b_overlap: in_ready=%b data=%h, want 1 13", a_in_ready, a_out_data);
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== 6'h05 || a_out_idx !== 1'b0) begin
         fails++;
         $display("FAIL b2b_no_bubble: vld=%b data=%h idx=%b, want 1 05 0", a_out_valid, a_out_data, a_out_idx);
      end
      @(posedge clk); #1;
      tests++;
      if (a_out_data !== 6'h0F || a_out_idx !== 1'b1) begin
         fails++;
         $display("FAIL b2b_beat3: data=%h idx=%b, want 0f 1", a_out_data, a_out_idx);
      end
      @(posedge clk); #1;
      tests++;
      if (a_word_count !== 8'd2 || a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_count: wc=%0d vld=%b, want 2 0", a_word_count, a_out_valid);
      end
      drain("b2b", 4);
   endtask

   task automatic test_stall();
      apply_reset();
      a_in_valid = 1'b1; a_in_data = 11'h553; a_out_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         a_in_data = 11'($urandom_range(0, 2047));
         @(posedge clk); #1;
         tests++;
         if (a_out_valid !== 1'b1 || a_out_data !== 6'h2A || a_out_idx !== 1'b0 || a_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold%0d: vld=%b data=%h idx=%b rdy=%b, want 1 2a 0 0",
                     i, a_out_valid, a_out_data, a_out_idx, a_in_ready);
         end
      end
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      drain("stall", 6);
      tests++;
      if (a_word_count !== 8'd1) begin
         fails++;
         $display("FAIL stall_count: wc=%0d, want 1", a_word_count);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      a_in_valid = 1'b1; a_in_data = 11'h553; a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      tests++;
      if (a_out_valid !== 1'b0 || a_word_count !== 8'd0 || a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL async_reset: vld=%b wc=%0d rdy=%b, want 0 0 1", a_out_valid, a_word_count, a_in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_wc = 0;
      a_in_valid = 1'b1; a_in_data = 11'h7FF;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      tests++;
      if (a_out_data !== 6'h3F) begin
         fails++;
         $display("FAIL async_after0: data=%h, want 3f", a_out_data);
      end
      @(posedge clk); #1;
      tests++;
      if (a_out_data !== 6'h1F || a_out_last !== 1'b1) begin
         fails++;
         $display("FAIL async_after1: data=%h last=%b, want 1f 1", a_out_data, a_out_last);
      end
      drain("async", 4);
   endtask

   task automatic test_wrap();
      apply_reset();
      a_out_ready = 1'b1;
      a_in_valid = 1'b1;
      for (int i = 0; i < 2000 && exp_wc < 256; i++) begin
         a_in_data = 11'($urandom_range(0, 2047));
         if (acc_cnt >= 256) a_in_valid = 1'b0;
         @(posedge clk); #1;
         if (acc_cnt >= 256) a_in_valid = 1'b0;
      end
      a_in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (exp_wc != 256 || acc_cnt != 256) begin
         fails++;
         $display("FAIL wrap_progress: words=%0d accepted=%0d, want 256 256", exp_wc, acc_cnt);
      end
      tests++;
      if (a_word_count !== 8'd0) begin
         fails++;
         $display("FAIL wrap_count: wc=%0d, want 0", a_word_count);
      end
      @(posedge clk); #1;
      drain("wrap", 4);
   endtask

   task automatic test_widths();
      apply_reset();
      b_in_valid = 1'b1; b_in_data = 10'h2C5; b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      tests++;
      if (b_out_valid !== 1'b1 || b_out_data !== 7'h05 || b_out_idx !== 1'b0) begin
         fails++;
         $display("FAIL widths_f0: vld=%b data=%h idx=%b, want 1 05 0", b_out_valid, b_out_data, b_out_idx);
      end
      @(posedge clk); #1;
      tests++;
      if (b_out_valid !== 1'b1 || b_out_data !== 7'h45 || b_out_idx !== 1'b1 || b_out_last !== 1'b1) begin
         fails++;
         $display("FAIL widths_f1: vld=%b data=%h idx=%b last=%b, want 1 45 1 1",
                  b_out_valid, b_out_data, b_out_idx, b_out_last);
      end
      @(posedge clk); #1;
      tests++;
      if (b_word_count !== 8'd1 || b_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL widths_count: wc=%0d vld=%b, want 1 0", b_word_count, b_out_valid);
      end
   endtask

   initial begin
      fork
         monitor_a();
      join_none
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_async_reset();
      test_wrap();
      test_widths();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/struct_field_unpacker.md
# struct_field_unpacker

Sequential reader for a packed two-field struct word `{field0, field1}`, with `field0` in the most-significant bits and `field1` in the least-significant bits. It accepts one packed word through a valid/ready input and emits the two fields one per beat, `field0` first, through a narrower valid/ready output. It sits downstream of blocks that build the word by bit-slice assignment, and is the field-by-field read side of that layout.

## Interface
Parameters:
- `FIELD0_WIDTH`, default 4: width of `field0` (≥1).
- `FIELD1_WIDTH`, default 4: width of `field1` (≥1).
- `OUT_WIDTH`, derived (localparam): max(`FIELD0_WIDTH`, `FIELD1_WIDTH`).

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  packed word offered.
- `in_ready`  output  1  word accepted on an edge where `in_valid && in_ready`.
- `in_data`  input  `FIELD0_WIDTH+FIELD1_WIDTH`  packed word:
  - `field0` = `[FIELD0_WIDTH+FIELD1_WIDTH-1:FIELD1_WIDTH]`
  - `field1` = `[FIELD1_WIDTH-1:0]`
- `out_valid`  output  1  field beat presented.
- `out_ready`  input  1  beat consumed on an edge where `out_valid && out_ready`.
- `out_data`  output  `OUT_WIDTH`  current field, zero-extended into the MSBs.
- `out_idx`  output  1  0 = `field0`, 1 = `field1`.
- `out_last`  output  1  high when `out_idx` = 1.
- `word_count`  output  8  count of completed words (`field1` beat consumed), wraps 255→0.

## Operation
- The FSM has three states: IDLE, SEND0, SEND1. It is reset to IDLE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On input handshake, capture `in_data` into the hold register and go to SEND0.
- SEND0:
  - `out_valid`=1, `out_data`=zext(`field0`), `out_idx`=0.
  - On output handshake, go to SEND1.
  - Otherwise hold; `out_data` must remain stable while stalled.
- SEND1:
  - `out_valid`=1, `out_data`=zext(`field1`), `out_idx`=1, `out_last`=1.
  - On output handshake, increment `word_count`. Then:
    - if `in_valid`=1, capture the new word and go to SEND0;
    - otherwise go to IDLE.
- `in_ready` = (state==IDLE) | (state==SEND1 & `out_ready`). This is the only combinational input-to-output path; `out_ready` feeds only `in_ready`.
- `out_valid`, `out_data`, `out_idx`, `out_last` and `word_count` are decoded from registers only.
- The hold register loads only on an input handshake, so `in_data` changes while not accepted have no effect.
- Width rule: `out_data` bits `[OUT_WIDTH-1:FIELDn_WIDTH]` are 0. When the two widths are equal, there is no padding.
- `in_valid` has no effect in SEND0, and `in_ready` is 0 there.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `word_count`=0, hold register 0.
- Reset is asynchronous: asserting `rst` mid-word drops the word immediately. `out_valid` falls without waiting for a clock.
- Latency: a word accepted at edge N presents `field0` after edge N. With `out_ready` held high:
  - `field0` is consumed at edge N+1;
  - `field1` is presented after edge N+1 and consumed at edge N+2.
- Throughput: with `in_valid` and `out_ready` held high, one word per 2 cycles and no bubble between words. The SEND1 handshake and the next input handshake occur on the same edge.
- `word_count` updates on the edge that consumes `field1`; the new value is visible after that edge.
- Stall: `out_ready`=0 holds state and all outputs indefinitely.

## Test plan
- Reset with `FIELD0_WIDTH`=6, `FIELD1_WIDTH`=5 (`OUT_WIDTH`=6) -> all outputs at reset values; `in_ready`=1.
- Single word, `in_data`=11'h553, `out_ready`=1:
  - beat 1: `out_data`=6'h2A, `out_idx`=0;
  - beat 2: `out_data`=6'h13, `out_idx`=1, `out_last`=1;
  - then `word_count`=1 and the block returns to IDLE.
- Back-to-back words 11'h553 then 11'h0AF, with `in_valid` and `out_ready` held high:
  - beats 2A, 13, 05, 0F on 4 consecutive cycles;
  - the second word is accepted on the same edge that consumes 13;
  - `word_count`=2.
- Stall: hold `out_ready`=0 for 5 cycles in SEND0 -> `out_data`=2A stable, `in_ready`=0, and a changing `in_data` is ignored. Release -> 2A then 13 as normal.
- Async reset asserted mid-SEND1 (between edges) -> `out_valid` drops immediately and `word_count` is unchanged at reset (0). After release, new word 11'h7FF yields 3F then 1F.
- Wrap: complete 256 words -> `word_count` returns to 0. Also run with `FIELD0_WIDTH`=3, `FIELD1_WIDTH`=7: `in_data`=10'h2C5 yields `field0`=7'h05 and `field1`=7'h45.
